// File: rtl/ffr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ffr_pkg
//  Description : Shared mode constants and per-bit JK / SR encodings for the
//                multi-mode register bank.
//  Revision    : 1.0  initial release
// ============================================================================
package ffr_pkg;

  // Operation select values carried on the 3-bit mode input
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_D    = 3'b001;
  localparam logic [2:0] MODE_JK   = 3'b010;
  localparam logic [2:0] MODE_T    = 3'b011;
  localparam logic [2:0] MODE_SR   = 3'b100;
  localparam logic [2:0] MODE_SHL  = 3'b101;
  localparam logic [2:0] MODE_SHR  = 3'b110;
  localparam logic [2:0] MODE_ROL  = 3'b111;

  // Per-bit JK action, indexed by {j, k}
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_CLEAR  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  // Per-bit SR action, indexed by {s, r}; both asserted is a conflict
  typedef enum logic [1:0] {
    SR_HOLD     = 2'b00,
    SR_CLEAR    = 2'b01,
    SR_SET      = 2'b10,
    SR_CONFLICT = 2'b11
  } sr_op_e;

endpackage
`default_nettype wire

// File: rtl/ffr_bit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : ffr_bit_cell
//  Description : Combinational next-state function for one storage bit of the
//                register bank. Neighbour bits are wired by the parent so the
//                same cell serves LSB, MSB and interior positions.
//  Revision    : 1.0  initial release
// ============================================================================
module ffr_bit_cell #(
  parameter bit IS_LSB = 1'b0,
  parameter bit IS_MSB = 1'b0
) (
  input  logic       q_i,        // current value of this bit
  input  logic       a_i,        // d / j / t / s
  input  logic       b_i,        // k / r
  input  logic [2:0] mode_i,
  input  logic       lo_nbr_i,   // next-lower bit (MSB of word at the LSB, for rotate)
  input  logic       hi_nbr_i,   // next-higher bit (unused at the MSB)
  input  logic       sin_i,
  output logic       q_next_o,
  output logic       sr_conf_o
);
  import ffr_pkg::*;

  // Select the next value of this bit according to the active discipline
  always_comb begin
    q_next_o  = q_i;
    sr_conf_o = 1'b0;
    case (mode_i)
      MODE_HOLD: q_next_o = q_i;
      MODE_D:    q_next_o = a_i;
      MODE_JK: begin
        case (jk_op_e'({a_i, b_i}))
          JK_HOLD:   q_next_o = q_i;
          JK_CLEAR:  q_next_o = 1'b0;
          JK_SET:    q_next_o = 1'b1;
          default:   q_next_o = ~q_i;
        endcase
      end
      MODE_T:    q_next_o = q_i ^ a_i;
      MODE_SR: begin
        case (sr_op_e'({a_i, b_i}))
          SR_SET:      q_next_o = 1'b1;
          SR_CLEAR:    q_next_o = 1'b0;
          SR_CONFLICT: sr_conf_o = 1'b1;  // bit holds, conflict is flagged
          default:     q_next_o = q_i;
        endcase
      end
      MODE_SHL:  q_next_o = IS_LSB ? sin_i : lo_nbr_i;
      MODE_SHR:  q_next_o = IS_MSB ? sin_i : hi_nbr_i;
      MODE_ROL:  q_next_o = lo_nbr_i;
      default:   q_next_o = q_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ff_register_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ff_register_bank
//  Description : WIDTH-bit register bank with selectable per-cycle update
//                discipline (D, JK, T, SR, shift/rotate), serial output and
//                registered SR-conflict / state-change pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module ff_register_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,     // asynchronous, active low
  input  logic             en,
  input  logic             clr,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             sout,
  output logic             sr_err,
  output logic             chg
);
  import ffr_pkg::*;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             sr_err_q, sr_err_d;
  logic             chg_q, chg_d;

  logic [WIDTH-1:0] w_cell_next;
  logic [WIDTH-1:0] w_conf;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_hi;
  logic             w_sr_any;

  // One next-state cell per bit; the LSB sees the MSB as its lower
  // neighbour so that rotate-left wraps around.
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i == 0) begin : g_lo_wrap
        assign w_lo[i] = q_q[WIDTH-1];
      end else begin : g_lo_nbr
        assign w_lo[i] = q_q[i-1];
      end

      if (i == WIDTH - 1) begin : g_hi_edge
        assign w_hi[i] = 1'b0;
      end else begin : g_hi_nbr
        assign w_hi[i] = q_q[i+1];
      end

      ffr_bit_cell #(
        .IS_LSB (i == 0),
        .IS_MSB (i == WIDTH - 1)
      ) u_cell (
        .q_i       (q_q[i]),
        .a_i       (a[i]),
        .b_i       (b[i]),
        .mode_i    (mode),
        .lo_nbr_i  (w_lo[i]),
        .hi_nbr_i  (w_hi[i]),
        .sin_i     (sin),
        .q_next_o  (w_cell_next[i]),
        .sr_conf_o (w_conf[i])
      );
    end
  endgenerate

  assign w_sr_any = |w_conf;

  // Next-state selection: clr beats en, en gates the per-mode update
  always_comb begin
    q_d      = q_q;
    sout_d   = sout_q;
    sr_err_d = 1'b0;
    chg_d    = 1'b0;
    if (clr) begin
      q_d    = RESET_VAL;
      sout_d = 1'b0;
      chg_d  = (q_q != RESET_VAL);
    end else if (en) begin
      q_d = w_cell_next;
      if (mode == MODE_SHL || mode == MODE_ROL) begin
        sout_d = q_q[WIDTH-1];
      end else if (mode == MODE_SHR) begin
        sout_d = q_q[0];
      end
      sr_err_d = (mode == MODE_SR) && w_sr_any;
      chg_d    = (w_cell_next != q_q);
    end
  end

  // State and status registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q      <= RESET_VAL;
      sout_q   <= 1'b0;
      sr_err_q <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      q_q      <= q_d;
      sout_q   <= sout_d;
      sr_err_q <= sr_err_d;
      chg_q    <= chg_d;
    end
  end

  assign q      = q_q;
  assign q_n    = ~q_q;
  assign sout   = sout_q;
  assign sr_err = sr_err_q;
  assign chg    = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_ff_register_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ff_register_bank
//  Description : Self-checking bench for ff_register_bank: three instances
//                (8-bit RESET_VAL=A5, 8-bit RESET_VAL=00, 1-bit) driven from
//                shared stimulus and compared to a word-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ff_register_bank;
  import ffr_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, clr, sin;
  logic [2:0] mode;
  logic [7:0] a, b;

  logic [7:0] qA, qnA, qB, qnB;
  logic       qC, qnC;
  logic       soutA, errA, chgA, soutB, errB, chgB, soutC, errC, chgC;

  always #5 clk = ~clk;

  ff_register_bank #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut_a (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .a(a), .b(b), .sin(sin),
    .q(qA), .q_n(qnA), .sout(soutA), .sr_err(errA), .chg(chgA));

  ff_register_bank #(.WIDTH(8), .RESET_VAL(8'h00)) u_dut_b (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .a(a), .b(b), .sin(sin),
    .q(qB), .q_n(qnB), .sout(soutB), .sr_err(errB), .chg(chgB));

  ff_register_bank #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut_c (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .a(a[0]), .b(b[0]), .sin(sin),
    .q(qC), .q_n(qnC), .sout(soutC), .sr_err(errC), .chg(chgC));

  // Instance outputs gathered for indexed comparison
  logic [7:0] dq[3], dqn[3];
  logic       dso[3], der[3], dch[3];
  always_comb begin
    dq[0] = qA;  dqn[0] = qnA;  dso[0] = soutA; der[0] = errA; dch[0] = chgA;
    dq[1] = qB;  dqn[1] = qnB;  dso[1] = soutB; der[1] = errB; dch[1] = chgB;
    dq[2] = {7'b0, qC}; dqn[2] = {7'b0, qnC}; dso[2] = soutC; der[2] = errC; dch[2] = chgC;
  end

  // Reference model state
  int         W[3]  = '{8, 8, 1};
  logic [7:0] RV[3] = '{8'hA5, 8'h00, 8'h00};
  logic [7:0] mq[3];
  logic       ms[3], me[3], mc[3];

  int errors = 0;
  int checks = 0;

  function automatic logic [7:0] wmask(input int w);
    return 8'hFF >> (8 - w);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k] = RV[k]; ms[k] = 1'b0; me[k] = 1'b0; mc[k] = 1'b0;
    end
  endtask

  // Word-level next state from the characteristic equations
  task automatic model_edge();
    logic [7:0] m, cur, aa, bb, nx;
    logic       so, er, ch;
    for (int k = 0; k < 3; k++) begin
      m = wmask(W[k]); cur = mq[k]; aa = a & m; bb = b & m;
      nx = cur; so = ms[k]; er = 1'b0; ch = 1'b0;
      if (clr) begin
        nx = RV[k]; so = 1'b0; ch = (cur != RV[k]);
      end else if (en) begin
        case (mode)
          MODE_D:   nx = aa;
          MODE_JK:  nx = (aa & ~cur) | (~bb & cur);
          MODE_T:   nx = cur ^ aa;
          MODE_SR:  begin nx = (cur | (aa & ~bb)) & ~(bb & ~aa); er = |(aa & bb); end
          MODE_SHL: begin nx = (cur << 1) | {7'b0, sin}; so = cur[W[k]-1]; end
          MODE_SHR: begin nx = (cur >> 1) | ({7'b0, sin} << (W[k] - 1)); so = cur[0]; end
          MODE_ROL: begin nx = (cur << 1) | (cur >> (W[k] - 1)); so = cur[W[k]-1]; end
          default:  nx = cur;
        endcase
        nx = nx & m;
        ch = (nx != cur);
      end
      mq[k] = nx; ms[k] = so; me[k] = er; mc[k] = ch;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; mode = MODE_HOLD; a = 8'h00; b = 8'h00; sin = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (qA !== 8'hA5) begin errors++; $display("FAIL reset_q: got %h want a5", qA); end
    checks++; if (qnA !== 8'h5A) begin errors++; $display("FAIL reset_qn: got %h want 5a", qnA); end
    checks++; if ({soutA, errA, chgA} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {soutA, errA, chgA}); end
    checks++; if (qB !== 8'h00 || qC !== 1'b0) begin errors++; $display("FAIL reset_other: got %h/%b want 00/0", qB, qC); end
    // Held across an edge while rst stays low, even with a load requested
    @(negedge clk);
    en = 1'b1; mode = MODE_D; a = 8'h3C;
    @(posedge clk);
    #1;
    checks++; if (qA !== 8'hA5 || chgA !== 1'b0) begin errors++; $display("FAIL reset_hold: got %h/%b want a5/0", qA, chgA); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (qA !== 8'h3C) begin errors++; $display("FAIL release_load: got %h want 3c", qA); end
    checks++; if (chgA !== 1'b1) begin errors++; $display("FAIL release_chg: got %b want 1", chgA); end
    en = 1'b0;
    tick();
    checks++; if (chgA !== 1'b0 || qA !== 8'h3C) begin errors++; $display("FAIL chg_pulse: got %b/%h want 0/3c", chgA, qA); end
  endtask

  task automatic test_jk_t();
    en = 1'b1; mode = MODE_D; a = 8'h0F; tick();
    mode = MODE_JK; a = 8'hF0; b = 8'h3C; tick();
    checks++; if (qA !== 8'hF3) begin errors++; $display("FAIL jk: got %h want f3", qA); end
    mode = MODE_T; a = 8'hFF; tick();
    checks++; if (qA !== 8'h0C) begin errors++; $display("FAIL toggle: got %h want 0c", qA); end
  endtask

  task automatic test_sr_conflict();
    en = 1'b1; mode = MODE_D; a = 8'h00; tick();
    mode = MODE_SR; a = 8'h81; b = 8'h01; tick();
    checks++; if (qA !== 8'h80) begin errors++; $display("FAIL sr_q: got %h want 80", qA); end
    checks++; if (errA !== 1'b1) begin errors++; $display("FAIL sr_err_set: got %b want 1", errA); end
    mode = MODE_HOLD; tick();
    checks++; if (errA !== 1'b0 || qA !== 8'h80) begin errors++; $display("FAIL sr_err_clear: got %b/%h want 0/80", errA, qA); end
  endtask

  task automatic test_shift();
    en = 1'b1; mode = MODE_D; a = 8'h81; tick();
    mode = MODE_SHL; sin = 1'b0; tick();
    checks++; if (qA !== 8'h02 || soutA !== 1'b1) begin errors++; $display("FAIL shl: got %h/%b want 02/1", qA, soutA); end
    mode = MODE_SHR; sin = 1'b1; tick();
    checks++; if (qA !== 8'h81 || soutA !== 1'b0) begin errors++; $display("FAIL shr: got %h/%b want 81/0", qA, soutA); end
    mode = MODE_ROL; tick();
    checks++; if (qA !== 8'h03 || soutA !== 1'b1) begin errors++; $display("FAIL rol: got %h/%b want 03/1", qA, soutA); end
  endtask

  task automatic test_priority();
    en = 1'b0; clr = 1'b1; tick();
    en = 1'b1; mode = MODE_D; a = 8'hFF; tick();
    checks++; if (qB !== 8'h00 || chgB !== 1'b0) begin errors++; $display("FAIL clr_wins: got %h/%b want 00/0", qB, chgB); end
    checks++; if (qA !== 8'hA5) begin errors++; $display("FAIL clr_resetval: got %h want a5", qA); end
    clr = 1'b0; en = 1'b0; mode = MODE_T; a = 8'hFF; tick();
    checks++; if (qB !== 8'h00 || chgB !== 1'b0) begin errors++; $display("FAIL en_hold: got %h/%b want 00/0", qB, chgB); end
  endtask

  task automatic test_width1();
    en = 1'b0; clr = 1'b1; tick();
    clr = 1'b0; en = 1'b1; mode = MODE_SHL; sin = 1'b1; tick();
    checks++; if (qC !== 1'b1 || soutC !== 1'b0) begin errors++; $display("FAIL w1_shl: got %b/%b want 1/0", qC, soutC); end
    mode = MODE_ROL; sin = 1'b0; tick();
    checks++; if (qC !== 1'b1 || soutC !== 1'b1) begin errors++; $display("FAIL w1_rol: got %b/%b want 1/1", qC, soutC); end
  endtask

  task automatic test_reset_midshift();
    en = 1'b1; mode = MODE_D; a = 8'h5A; tick();
    mode = MODE_SHL; sin = 1'b1; tick(); tick();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (qA !== 8'hA5 || soutA !== 1'b0) begin errors++; $display("FAIL midshift_reset: got %h/%b want a5/0", qA, soutA); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++; if (qA !== 8'h4B || soutA !== 1'b1) begin errors++; $display("FAIL after_reset_shift: got %h/%b want 4b/1", qA, soutA); end
    // A5 shifted left with sin=1 gives 4B, bit 7 (1) leaves on sout
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      clr  = ($urandom_range(0, 11) == 0);
      mode = 3'($urandom_range(0, 7));
      a    = 8'($urandom);
      b    = 8'($urandom);
      sin  = 1'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dq[k] !== mq[k] || dqn[k] !== (~mq[k] & wmask(W[k])) || dso[k] !== ms[k] ||
            der[k] !== me[k] || dch[k] !== mc[k]) begin
          errors++;
          $display("FAIL random[%0d] inst%0d: got q=%h qn=%h so=%b err=%b chg=%b want q=%h qn=%h so=%b err=%b chg=%b",
                   n, k, dq[k], dqn[k], dso[k], der[k], dch[k],
                   mq[k], ~mq[k] & wmask(W[k]), ms[k], me[k], mc[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_jk_t();
    test_sr_conflict();
    test_shift();
    test_priority();
    test_width1();
    test_reset_midshift();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
